calc_op_sequencer: RTL and testbench
====================================

Name: calc_op_sequencer

Overview:
- Sequences one arithmetic operation on the two decimal operands produced by the keypad operand reader (In1, In2, each 0..99).
- Operations: add, subtract, shift-add multiply and restoring divide. Multiply and divide are iterative, one bit per clock, so no wide combinational multiplier/divider is built.
- Sits between the operand reader and the display/BCD stage. It runs a start/busy/done handshake and holds each result stable until the next accepted operation.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- In1  in  WIDTH  operand A (dividend/minuend)
- In2  in  WIDTH  operand B (divisor/subtrahend)
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- start  in  1  request; sampled only in IDLE
- busy  out  1  high whenever FSM not in IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  2*WIDTH  sum / |difference| / product / quotient
- remainder  out  WIDTH  division remainder, 0 for other ops
- neg  out  1  subtract result negative (In1 < In2)
- err  out  1  divide by zero

Behaviour:
- Reset (rst=1 at a rising edge):
  - FSM goes to IDLE.
  - busy, done, neg and err are 0; result and remainder are 0; iteration counter and internal registers are cleared.
  - Reset has priority over every other event, including in mid-iteration. No done is produced for an aborted operation.
- FSM states: IDLE, CALC, DONE.
- Accept edge E0: start=1 while in IDLE.
  - In1, In2 and op are latched into internal registers.
  - FSM goes to CALC; the counter is loaded with WIDTH.
  - Operand or op changes after E0 have no effect.
- CALC, add: at E1, result = In1+In2, zero-extended; neg=0, err=0, remainder=0; FSM goes to DONE.
- CALC, sub: at E1, if A>=B then result=A-B and neg=0, else result=B-A and neg=1; FSM goes to DONE.
- CALC, mul (shift-add):
  - Registers: 2*WIDTH multiplicand register, WIDTH multiplier register, accumulator.
  - Each edge: if multiplier[0]=1, acc += mcand; then mcand <<= 1, mplr >>= 1, counter decrements.
  - Exactly WIDTH iteration edges (E1..E_WIDTH). At E_WIDTH the result register is loaded with the final acc and the FSM goes to DONE.
- CALC, div (restoring):
  - Partial remainder is WIDTH+1 bits.
  - Each edge: shift in the next dividend MSB, trial-subtract B, keep the difference if non-negative and set the quotient bit.
  - WIDTH iteration edges. At E_WIDTH: result = quotient (zero-extended), remainder = final remainder; FSM goes to DONE.
- Divide by zero (op=11, B=0):
  - Detected in the first CALC cycle; no iteration is performed.
  - At E1: err=1, result = all ones, remainder=0; FSM goes to DONE.
- Output update rule: result, remainder, neg and err update only on the edge that enters DONE. They hold their value through DONE and IDLE until the next operation completes.
  - err and neg are cleared on the completion edge of any operation that does not set them.
- DONE:
  - done=1 for exactly this one cycle; the next edge returns to IDLE.
  - start is ignored in DONE.
- Latency from E0 to done high: 1 cycle for add, sub and div-by-zero; WIDTH cycles for mul and div.
- busy: rises the cycle after E0, stays high through the DONE cycle, and is low in IDLE.
- start while busy: ignored, not queued.
- start held high continuously: a new operation is accepted on every edge at which the FSM is in IDLE, i.e. one cycle after each done.
- Width rules:
  - add fits in WIDTH+1 bits and sub fits in WIDTH bits; both are zero-extended to 2*WIDTH.
  - mul max (2^WIDTH-1)^2 fits in 2*WIDTH bits; no overflow is possible.

Test Plan:
- add In1=45, In2=37, start one cycle → next cycle done=1, result=82, neg=0, busy high exactly 2 cycles.
- sub In1=12, In2=30 → result=18, neg=1; then sub 30-12 → result=18, neg=0.
- mul 99×99 → done exactly 8 cycles after E0, result=9801; change In1/In2 during CALC → result unchanged. mul 0×55 → result=0.
- div 99/7 → result=14, remainder=1 after 8 cycles; div 5/0 → 1 cycle, err=1, result=0xFFFF, remainder=0; following add 1+1 → err=0, result=2.
- Pulse start during CALC and during DONE → ignored, single done. Assert rst at the 4th mul iteration → next cycle busy=0, result=0, no done pulse.
- start held high, op=00, In1=1, In2=2 → done pulses every 3 cycles (E0, DONE, IDLE), result=3 each time.

Source files
------------

// File: rtl/calc_op_sequencer.sv
// Sequences one add/sub/mul/div on two latched operands with a start/busy/done handshake.
// Multiply is shift-add and divide is restoring, both one bit per clock.
module calc_op_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     In1,
    input  logic [WIDTH-1:0]     In2,
    input  logic [1:0]           op,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 neg,
    output logic                 err
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [1:0]        r_op;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplr;
    logic [RW-1:0]     r_acc;
    logic [WIDTH-1:0]  r_prem;
    logic [WIDTH-1:0]  r_dq;

    logic [WIDTH:0]    w_sum;
    logic              w_a_ge_b;
    logic [WIDTH-1:0]  w_diff;
    logic [RW-1:0]     w_acc_next;
    logic [WIDTH:0]    w_div_shift;
    logic              w_div_ge;
    logic [WIDTH-1:0]  w_prem_next;
    logic [WIDTH-1:0]  w_dq_next;
    logic              w_last;

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_a_ge_b   = (r_a >= r_b);
    assign w_diff     = w_a_ge_b ? (r_a - r_b) : (r_b - r_a);
    assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

    // r_dq holds the unconsumed dividend bits on the left and the quotient bits
    // collected so far on the right; its MSB is the next dividend bit.
    assign w_div_shift = {r_prem, r_dq[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_prem_next = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_b}) : WIDTH'(w_div_shift);
    assign w_dq_next   = {r_dq[WIDTH-2:0], w_div_ge};
    assign w_last      = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_prem    <= '0;
            r_dq      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= In1;
                        r_b     <= In2;
                        r_op    <= op;
                        r_mcand <= RW'(In1);
                        r_mplr  <= In2;
                        r_acc   <= '0;
                        r_prem  <= '0;
                        r_dq    <= In1;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_CALC;
                        busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    case (r_op)
                        OP_ADD: begin
                            result    <= RW'(w_sum);
                            remainder <= '0;
                            neg       <= 1'b0;
                            err       <= 1'b0;
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                        end
                        OP_SUB: begin
                            result    <= RW'(w_diff);
                            remainder <= '0;
                            neg       <= ~w_a_ge_b;
                            err       <= 1'b0;
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                        end
                        OP_MUL: begin
                            r_acc   <= w_acc_next;
                            r_mcand <= r_mcand << 1;
                            r_mplr  <= r_mplr >> 1;
                            r_cnt   <= r_cnt - CW'(1);
                            if (w_last) begin
                                result    <= w_acc_next;
                                remainder <= '0;
                                neg       <= 1'b0;
                                err       <= 1'b0;
                                r_state   <= S_DONE;
                                done      <= 1'b1;
                            end
                        end
                        default: begin
                            // Divide by zero short-circuits before any iteration.
                            if (r_b == '0) begin
                                result    <= '1;
                                remainder <= '0;
                                neg       <= 1'b0;
                                err       <= 1'b1;
                                r_state   <= S_DONE;
                                done      <= 1'b1;
                            end else begin
                                r_prem <= w_prem_next;
                                r_dq   <= w_dq_next;
                                r_cnt  <= r_cnt - CW'(1);
                                if (w_last) begin
                                    result    <= RW'(w_dq_next);
                                    remainder <= w_prem_next;
                                    neg       <= 1'b0;
                                    err       <= 1'b0;
                                    r_state   <= S_DONE;
                                    done      <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: hand-computed results, latencies and handshake checks.
module tb_calc_op_sequencer;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   In1;
    logic [WIDTH-1:0]   In2;
    logic [1:0]         op;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   remainder;
    logic               neg;
    logic               err;

    int checks = 0;
    int errors = 0;

    calc_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .In1       (In1),
        .In2       (In2),
        .op        (op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .neg       (neg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, optionally disturb inputs/start mid-run, wait for done.
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit scramble, input bit poke, output int lat);
        In1   = a;
        In2   = b;
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_e0", 32'(busy), 32'd1);
        if (scramble) begin
            In1 = 8'hAA;
            In2 = 8'h55;
            op  = 2'b00;
        end
        lat = 0;
        while (!done) begin
            if (poke && lat == 2) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
            if (lat > 40) begin
                check("done_timeout", 32'(done), 32'd1);
                break;
            end
        end
    endtask

    int lat;
    int dcount;

    initial begin
        rst   = 1'b1;
        In1   = '0;
        In2   = '0;
        op    = '0;
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_neg_err", {30'd0, neg, err}, 32'd0);

        // add 45+37
        run_op(2'b00, 8'd45, 8'd37, 1'b0, 1'b0, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_res", 32'(result), 32'd82);
        check("add_neg", 32'(neg), 32'd0);
        check("add_busy_done", 32'(busy), 32'd1);
        tick();
        check("add_busy_low", 32'(busy), 32'd0);
        check("add_done_low", 32'(done), 32'd0);
        check("add_hold", 32'(result), 32'd82);

        // sub both directions
        run_op(2'b01, 8'd12, 8'd30, 1'b0, 1'b0, lat);
        check("sub_neg_res", 32'(result), 32'd18);
        check("sub_neg_flag", 32'(neg), 32'd1);
        tick();
        run_op(2'b01, 8'd30, 8'd12, 1'b0, 1'b0, lat);
        check("sub_pos_res", 32'(result), 32'd18);
        check("sub_pos_flag", 32'(neg), 32'd0);
        tick();

        // mul 99*99 with operands disturbed after acceptance
        run_op(2'b10, 8'd99, 8'd99, 1'b1, 1'b0, lat);
        check("mul_lat", 32'(lat), 32'd8);
        check("mul_res", 32'(result), 32'd9801);
        check("mul_rem", 32'(remainder), 32'd0);
        tick();
        run_op(2'b10, 8'd0, 8'd55, 1'b0, 1'b0, lat);
        check("mul_zero", 32'(result), 32'd0);
        tick();
        run_op(2'b10, 8'd255, 8'd255, 1'b0, 1'b0, lat);
        check("mul_max", 32'(result), 32'd65025);
        tick();

        // div 99/7 with start pulsed during CALC and during DONE
        run_op(2'b11, 8'd99, 8'd7, 1'b0, 1'b1, lat);
        check("div_lat", 32'(lat), 32'd8);
        check("div_quot", 32'(result), 32'd14);
        check("div_rem", 32'(remainder), 32'd1);
        check("div_err", 32'(err), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_busy", 32'(busy), 32'd0);
        tick();
        check("start_in_done_ignored", 32'(busy), 32'd0);

        // divide by zero, then add clears err
        run_op(2'b11, 8'd5, 8'd0, 1'b0, 1'b0, lat);
        check("dz_lat", 32'(lat), 32'd1);
        check("dz_err", 32'(err), 32'd1);
        check("dz_res", 32'(result), 32'hFFFF);
        check("dz_rem", 32'(remainder), 32'd0);
        tick();
        run_op(2'b00, 8'd1, 8'd1, 1'b0, 1'b0, lat);
        check("add_after_dz_err", 32'(err), 32'd0);
        check("add_after_dz_res", 32'(result), 32'd2);
        tick();

        // reset during the 4th mul iteration aborts without done
        In1   = 8'd99;
        In2   = 8'd99;
        op    = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", 32'(dcount), 32'd0);

        // start held high: done on every third edge
        In1   = 8'd1;
        In2   = 8'd2;
        op    = 2'b00;
        start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("held_done", 32'(done), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (done) check("held_res", 32'(result), 32'd3);
        end
        start = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
